// File: rtl/baud_rate_gen_if.sv
// Configuration bus for baud_rate_gen.
//   cfg_wr   : divisor write strobe (master -> slave)
//   div_int  : integer divisor, DIV_W bits
//   div_frac : fractional divisor, FRAC_W bits
//   cfg_busy : a written divisor is waiting to take effect (slave -> master)
//   cfg_ack  : one-cycle pulse on the edge the divisor takes effect
interface baud_rate_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 8
);
  logic              cfg_wr;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              cfg_busy;
  logic              cfg_ack;

  modport master (output cfg_wr, div_int, div_frac, input cfg_busy, cfg_ack);
  modport slave  (input cfg_wr, div_int, div_frac, output cfg_busy, cfg_ack);
endinterface

// File: rtl/baud_rate_gen.sv
// Fractional baud-rate tick generator for a UART.
// An up-counter runs 0..T with T = act_int + carry; each wrap raises b_tick
// for one cycle. os_phase counts b_ticks modulo OVERSAMPLING; mid_tick and
// bit_tick mark the bit centre and bit boundary.
// Optional feature macro: BAUD_FRAC_EN builds the fractional accumulator
// (carry from frac_acc + act_frac); without it the period is act_int+1 and
// div_frac is ignored.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   en        : count enable; while low, counters hold and ticks are 0
//   resync    : restart the bit phase (RX start-bit alignment)
//   cfg       : divisor write bus (baud_rate_gen_if.slave)
//   b_tick    : oversample tick
//   mid_tick  : bit-centre tick
//   bit_tick  : bit-boundary tick
//   os_phase  : oversample phase within the bit
module baud_rate_gen #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int OVERSAMPLING = 16,
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              resync,
  baud_rate_gen_if.slave                    cfg,
  output logic                              b_tick,
  output logic                              mid_tick,
  output logic                              bit_tick,
  output logic [$clog2(OVERSAMPLING)-1:0]   os_phase
);
  localparam int PH_W = $clog2(OVERSAMPLING);
  localparam longint unsigned DEN = 64'(BAUD_RATE) * 64'(OVERSAMPLING);
  localparam logic [DIV_W-1:0] RST_INT = DIV_W'(64'(CLK_FREQ) / DEN - 64'd1);
  localparam logic [PH_W-1:0] MID_PH = PH_W'(OVERSAMPLING / 2);

  logic [DIV_W:0]   cnt;
  logic [DIV_W:0]   term;
  logic [DIV_W-1:0] act_int;
  logic [DIV_W-1:0] shd_int;
  logic [PH_W-1:0]  next_phase;
  logic             carry;
  logic             wrap;
  logic             apply;

`ifdef BAUD_FRAC_EN
  localparam logic [FRAC_W-1:0] RST_FRAC =
    FRAC_W'((64'(CLK_FREQ) << FRAC_W) / DEN);

  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] shd_frac;
  logic [FRAC_W-1:0] frac_sum;

  // Carry of the current period stretches it by one cycle.
  assign {carry, frac_sum} = {1'b0, frac_acc} + {1'b0, act_frac};
`else
  logic unused_div_frac;

  assign carry           = 1'b0;
  assign unused_div_frac = ^cfg.div_frac;
`endif

  assign term       = {1'b0, act_int} + {{DIV_W{1'b0}}, carry};
  assign wrap       = en && (cnt == term);
  assign next_phase = os_phase + 1'b1;
  // A write arriving on the apply edge overwrites the shadow and defers
  // the apply, so back-to-back writes still yield a single ack.
  assign apply      = cfg.cfg_busy && !cfg.cfg_wr && (wrap || !en);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      os_phase     <= '0;
      b_tick       <= 1'b0;
      mid_tick     <= 1'b0;
      bit_tick     <= 1'b0;
      cfg.cfg_busy <= 1'b0;
      cfg.cfg_ack  <= 1'b0;
      act_int      <= RST_INT;
      shd_int      <= RST_INT;
`ifdef BAUD_FRAC_EN
      frac_acc     <= '0;
      act_frac     <= RST_FRAC;
      shd_frac     <= RST_FRAC;
`endif
    end else begin
      b_tick      <= 1'b0;
      mid_tick    <= 1'b0;
      bit_tick    <= 1'b0;
      cfg.cfg_ack <= 1'b0;

      if (cfg.cfg_wr) begin
        shd_int  <= cfg.div_int;
`ifdef BAUD_FRAC_EN
        shd_frac <= cfg.div_frac;
`endif
      end

      if (resync) begin
        cnt      <= '0;
        os_phase <= '0;
`ifdef BAUD_FRAC_EN
        frac_acc <= '0;
`endif
        if (cfg.cfg_wr) begin
          act_int      <= cfg.div_int;
`ifdef BAUD_FRAC_EN
          act_frac     <= cfg.div_frac;
`endif
          cfg.cfg_ack  <= 1'b1;
          cfg.cfg_busy <= 1'b0;
        end else if (cfg.cfg_busy) begin
          act_int      <= shd_int;
`ifdef BAUD_FRAC_EN
          act_frac     <= shd_frac;
`endif
          cfg.cfg_ack  <= 1'b1;
          cfg.cfg_busy <= 1'b0;
        end
      end else begin
        if (wrap) begin
          cnt      <= '0;
          os_phase <= next_phase;
          b_tick   <= 1'b1;
          bit_tick <= (next_phase == '0);
          mid_tick <= (next_phase == MID_PH);
`ifdef BAUD_FRAC_EN
          frac_acc <= frac_sum;
`endif
        end else if (en) begin
          cnt <= cnt + 1'b1;
        end

        if (apply) begin
          act_int      <= shd_int;
`ifdef BAUD_FRAC_EN
          act_frac     <= shd_frac;
`endif
          cfg.cfg_ack  <= 1'b1;
          cfg.cfg_busy <= 1'b0;
        end else if (cfg.cfg_wr) begin
          cfg.cfg_busy <= 1'b1;
        end
      end
    end
  end
endmodule
